fifo_reader: RTL

Read-side client for the FIFO controller/datapath. It watches fifo_empty, issues single-cycle read strobes that respect the controller's two-cycle read cadence, and captures the returned word after a fixed read latency. Captured words go into a 2-entry output buffer and are presented on a valid/ready stream to the downstream consumer. It sits between the FIFO and any block that consumes FIFO data.

---
 rtl/fifo_reader.sv | 107 ++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// Read-side client for the FIFO controller: paces single-cycle read strobes,
// captures returned words after READ_LATENCY cycles and streams them out via a 2-entry buffer.
module fifo_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   fifo_empty,
    output logic                   fifo_re,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] rd_count
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

    state_t                state;
    state_t                next_state;
    logic [2:0]            lat_cnt;
    logic                  discard;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic                  capture;
    logic                  keep;
    logic                  pop;

    assign capture = (state == WAIT) && (lat_cnt == 3'd1);
    assign keep    = capture && !discard && !flush;
    assign pop     = m_valid && m_ready;
    assign m_valid = (count != 2'd0);
    assign m_data  = buf0;
    assign busy    = (state != IDLE);

    // A read is only started with a free buffer slot, so a capture can never overflow.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enable && !fifo_empty && count != 2'd2) next_state = REQ;
            REQ:  next_state = WAIT;
            WAIT: if (capture) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fifo_re  <= 1'b0;
            lat_cnt  <= 3'd0;
            discard  <= 1'b0;
            rd_count <= '0;
        end else begin
            state   <= next_state;
            fifo_re <= (next_state == REQ);
            if (state == REQ) begin
                lat_cnt <= LAT_INIT;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (capture) begin
                rd_count <= rd_count + COUNT_WIDTH'(1);
                discard  <= 1'b0;
            end else if (flush && state != IDLE) begin
                discard <= 1'b1;
            end
        end
    end

    // Output buffer: buf0 is the head; a simultaneous capture and pop keeps the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 2'd0;
            buf0  <= '0;
            buf1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (keep && pop) begin
            if (count == 2'd1) begin
                buf0 <= fifo_rd_data;
            end else begin
                buf0 <= buf1;
                buf1 <= fifo_rd_data;
            end
        end else if (keep) begin
            if (count == 2'd0) begin
                buf0 <= fifo_rd_data;
            end else begin
                buf1 <= fifo_rd_data;
            end
            count <= count + 2'd1;
        end else if (pop) begin
            buf0  <= buf1;
            count <= count - 2'd1;
        end
    end

endmodule
